div16_by8_seq: RTL and testbench

DIV16_BY8_SEQ -- requirements
Module: div16_by8_seq

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_step.sv | 26 ++
 rtl/div16_by8_seq.sv | 152 +++++++++++++++
 tb/tb_div16_by8_seq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and widths for the sequential 16/8 unsigned divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  // One bit wider than the divisor so a shifted partial remainder never overflows.
  localparam int REM_W      = 9;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
  } div_res_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module div_step
  import div_pkg::*;
(
  input  logic [REM_W-1:0]     rem_in,
  input  logic                 dvd_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [REM_W-1:0]     rem_out,
  output logic                 q_bit
);

  logic [REM_W-1:0] shifted;
  logic [REM_W-1:0] dvs_ext;

  // Shift the next dividend bit in; a set top bit of rem_in means the shifted
  // value is at least 512 and therefore always exceeds any 8-bit divisor.
  always_comb begin
    shifted = {rem_in[REM_W-2:0], dvd_bit};
    dvs_ext = {1'b0, divisor};
    q_bit   = rem_in[REM_W-1] | (shifted >= dvs_ext);
    rem_out = q_bit ? (shifted - dvs_ext) : shifted;
  end

endmodule

// File: rtl/div16_by8_seq.sv
// Sequential unsigned 16/8 restoring divider, BITS_PER_CYCLE (1 or 2) quotient bits per clock.
// Latency: out_valid 16/BITS_PER_CYCLE cycles after acceptance, 1 cycle for a zero divisor.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module div16_by8_seq
  import div_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int              STEPS    = DIVIDEND_W / BITS_PER_CYCLE;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  div_state_e            state;
  div_state_e            nxt_state;
  logic [DIVIDEND_W-1:0] dvd_sr;
  logic [DIVIDEND_W-1:0] src_dvd;
  logic [DIVIDEND_W-1:0] nxt_sr;
  logic [DIVISOR_W-1:0]  dvs_r;
  logic [DIVISOR_W-1:0]  src_dvs;
  logic [REM_W-1:0]      rem_r;
  logic [REM_W-1:0]      src_rem;
  logic [REM_W-1:0]      rem_chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] q_bits;
  logic [CNT_W-1:0]      cnt;
  logic                  accept;
  logic                  last_step;
  div_res_t              res;

  assign accept    = (state == IDLE) && in_valid;
  assign last_step = (state == BUSY) && (cnt == LAST_CNT);

  // The first step runs on the accept edge straight from the ports, so the
  // remaining steps need one edge fewer than the quotient width.
  always_comb begin
    if (state == IDLE) begin
      src_dvd = dividend;
      src_dvs = divisor;
      src_rem = '0;
    end else begin
      src_dvd = dvd_sr;
      src_dvs = dvs_r;
      src_rem = rem_r;
    end
  end

  assign rem_chain[0] = src_rem;

  // Chain of restoring steps; the first step in the chain yields the more significant bit.
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    div_step u_step (
      .rem_in  (rem_chain[g]),
      .dvd_bit (src_dvd[DIVIDEND_W-1-g]),
      .divisor (src_dvs),
      .rem_out (rem_chain[g+1]),
      .q_bit   (q_bits[BITS_PER_CYCLE-1-g])
    );
  end

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign nxt_sr = {src_dvd[DIVIDEND_W-BITS_PER_CYCLE-1:0], q_bits};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  // Next-state logic: zero divisor skips BUSY, DONE waits for the consumer.
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          nxt_state = (divisor == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last_step) begin
          nxt_state = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Operand/remainder shift registers, step counter and the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_sr <= '0;
      dvs_r  <= '0;
      rem_r  <= '0;
      cnt    <= '0;
      res    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (divisor == '0) begin
              res.quotient    <= '1;
              res.remainder   <= dividend[DIVISOR_W-1:0];
              res.div_by_zero <= 1'b1;
            end else begin
              dvs_r  <= divisor;
              dvd_sr <= nxt_sr;
              rem_r  <= rem_chain[BITS_PER_CYCLE];
              cnt    <= CNT_W'(1);
            end
          end
        end
        BUSY: begin
          dvd_sr <= nxt_sr;
          rem_r  <= rem_chain[BITS_PER_CYCLE];
          cnt    <= cnt + 1'b1;
          if (last_step) begin
            res.quotient    <= nxt_sr;
            res.remainder   <= rem_chain[BITS_PER_CYCLE][DIVISOR_W-1:0];
            res.div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = res.quotient;
  assign remainder   = res.remainder;
  assign div_by_zero = res.div_by_zero;

endmodule

// File: tb/tb_div16_by8_seq.sv
// Scoreboard bench for div16_by8_seq: one instance with 1 bit/cycle, one with 2 bits/cycle.
// Latency: directed cases check 16 / 8 / 1 cycle result latency.
// Backpressure: out_ready driven always-on, random, or held low per instance.
module tb_div16_by8_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid    [2];
  logic        in_ready    [2];
  logic [15:0] dividend    [2];
  logic [7:0]  divisor     [2];
  logic        out_valid   [2];
  logic        out_ready   [2];
  logic [15:0] quotient    [2];
  logic [7:0]  remainder   [2];
  logic        div_by_zero [2];

  int tests = 0;
  int fails = 0;
  int rdy_mode [2] = '{0, 0};   // 0: always ready, 1: random stalls, 2: never ready

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    logic [15:0] dd;
    logic [7:0]  dv;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  div16_by8_seq #(.BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .dividend(dividend[0]), .divisor(divisor[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .quotient(quotient[0]), .remainder(remainder[0]), .div_by_zero(div_by_zero[0])
  );

  div16_by8_seq #(.BITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .dividend(dividend[1]), .divisor(divisor[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .quotient(quotient[1]), .remainder(remainder[1]), .div_by_zero(div_by_zero[1])
  );

  // Reference: plain integer division, with the fixed zero-divisor convention.
  function automatic exp_t model(input logic [15:0] dd, input logic [7:0] dv);
    exp_t e;
    e.dd = dd;
    e.dv = dv;
    if (dv == 8'h00) begin
      e.q = 16'hFFFF;
      e.r = dd[7:0];
      e.z = 1'b1;
    end else begin
      e.q = dd / {8'h00, dv};
      e.r = 8'(dd % {8'h00, dv});
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input int k);
    exp_t e;
    if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
      tests++;
      fails++;
      $display("FAIL unexpected_result dut%0d: q=0x%0h r=0x%0h with nothing outstanding",
               k, quotient[k], remainder[k]);
      return;
    end
    if (k == 0) e = sb0.pop_front();
    else        e = sb1.pop_front();
    chk($sformatf("dut%0d_q(%h/%h)", k, e.dd, e.dv), 32'(quotient[k]), 32'(e.q));
    chk($sformatf("dut%0d_r(%h/%h)", k, e.dd, e.dv), 32'(remainder[k]), 32'(e.r));
    chk($sformatf("dut%0d_dbz(%h/%h)", k, e.dd, e.dv), 32'(div_by_zero[k]), 32'(e.z));
    if (e.dv != 8'h00) begin
      chk($sformatf("dut%0d_identity(%h/%h)", k, e.dd, e.dv),
          32'(quotient[k]) * 32'(e.dv) + 32'(remainder[k]), 32'(e.dd));
    end
  endtask

  // Consumer: out_ready changes just after each rising edge.
  initial begin
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        out_ready[k] = (rdy_mode[k] == 0) ? 1'b1 :
                       (rdy_mode[k] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // Monitor: pop and compare on every handshake, and check stalled results stay put.
  logic        hold [2] = '{1'b0, 1'b0};
  logic [15:0] hq   [2];
  logic [7:0]  hr   [2];
  logic        hz   [2];
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        hold[k] = 1'b0;
      end else begin
        if (hold[k]) begin
          chk($sformatf("dut%0d_hold_valid", k), 32'(out_valid[k]), 32'd1);
          chk($sformatf("dut%0d_hold_q", k), 32'(quotient[k]), 32'(hq[k]));
          chk($sformatf("dut%0d_hold_r", k), 32'(remainder[k]), 32'(hr[k]));
          chk($sformatf("dut%0d_hold_dbz", k), 32'(div_by_zero[k]), 32'(hz[k]));
        end
        if (out_valid[k] && out_ready[k]) begin
          pop_check(k);
          hold[k] = 1'b0;
        end else if (out_valid[k]) begin
          hold[k] = 1'b1;
          hq[k]   = quotient[k];
          hr[k]   = remainder[k];
          hz[k]   = div_by_zero[k];
        end else begin
          hold[k] = 1'b0;
        end
      end
    end
  end

  // Offer one pair and return just after the accepting edge.
  task automatic send(input int k, input logic [15:0] dd, input logic [7:0] dv,
                      input bit push, input bit keep);
    int n;
    @(negedge clk);
    in_valid[k] = 1'b1;
    dividend[k] = dd;
    divisor[k]  = dv;
    n = 0;
    while (!in_ready[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout dut%0d: in_ready stayed 0, expected 1 within 200 cycles", k);
      in_valid[k] = 1'b0;
      return;
    end
    if (push) begin
      if (k == 0) sb0.push_back(model(dd, dv));
      else        sb1.push_back(model(dd, dv));
    end
    @(posedge clk);
    #1;
    if (!keep) in_valid[k] = 1'b0;
  endtask

  // Count edges from acceptance (inclusive) until out_valid, then check the fixed values.
  task automatic wait_out(input int k, input int lat, input logic [15:0] q,
                          input logic [7:0] r, input logic z, input string name);
    int n;
    n = 1;
    while (!out_valid[k] && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(lat));
    chk({name, "_q"}, 32'(quotient[k]), 32'(q));
    chk({name, "_r"}, 32'(remainder[k]), 32'(r));
    chk({name, "_dbz"}, 32'(div_by_zero[k]), 32'(z));
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (((k == 0) ? sb0.size() : sb1.size()) != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("dut%0d_outstanding", k), 32'((k == 0) ? sb0.size() : sb1.size()), 32'd0);
  endtask

  task automatic random_run(input int k, input int count);
    logic [15:0] dd;
    logic [7:0]  dv;
    for (int i = 0; i < count; i++) begin
      dd = 16'($urandom);
      dv = 8'($urandom);
      case ($urandom_range(0, 7))
        0: dv = 8'hFF;
        1: dd = 16'h0000;
        2: dv = 8'h00;
        3: dv = 8'h01;
        4: dd = 16'hFFFF;
        default: ;
      endcase
      send(k, dd, dv, 1'b1, 1'b0);
    end
    drain(k);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      dividend[k] = 16'h0;
      divisor[k]  = 8'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", 32'(out_valid[0]), 32'd0);
    chk("reset_q", 32'(quotient[0]), 32'd0);
    chk("reset_r", 32'(remainder[0]), 32'd0);
    chk("reset_dbz", 32'(div_by_zero[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready[0]), 32'd1);
    chk("reset_in_ready_b2", 32'(in_ready[1]), 32'd1);

    // Directed values and latencies.
    send(0, 16'h427B, 8'h5D, 1'b1, 1'b0);
    wait_out(0, 16, 16'h00B7, 8'h00, 1'b0, "d427b");
    send(0, 16'h03E8, 8'h07, 1'b1, 1'b0);
    wait_out(0, 16, 16'h008E, 8'h06, 1'b0, "d03e8");
    send(0, 16'h1234, 8'h00, 1'b1, 1'b0);
    wait_out(0, 1, 16'hFFFF, 8'h34, 1'b1, "dz1234");
    send(0, 16'h0000, 8'h25, 1'b1, 1'b0);
    wait_out(0, 16, 16'h0000, 8'h00, 1'b0, "zero_dividend");
    send(1, 16'h03E8, 8'h07, 1'b1, 1'b0);
    wait_out(1, 8, 16'h008E, 8'h06, 1'b0, "b2_d03e8");
    send(1, 16'h1234, 8'h00, 1'b1, 1'b0);
    wait_out(1, 1, 16'hFFFF, 8'h34, 1'b1, "b2_dz1234");

    // Consumer stalls for five cycles; result must hold, then release to IDLE.
    rdy_mode[0] = 2;
    send(0, 16'hFFFF, 8'h01, 1'b1, 1'b0);
    wait_out(0, 16, 16'hFFFF, 8'h00, 1'b0, "stall");
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid[0]), 32'd1);
      chk("stall_q", 32'(quotient[0]), 32'h0000FFFF);
      chk("stall_r", 32'(remainder[0]), 32'd0);
      chk("stall_in_ready", 32'(in_ready[0]), 32'd0);
    end
    rdy_mode[0] = 0;
    n = 0;
    while (out_valid[0] && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_release_valid", 32'(out_valid[0]), 32'd0);
    chk("stall_release_in_ready", 32'(in_ready[0]), 32'd1);

    // Abort mid-operation with in_valid still asserted.
    send(0, 16'hABCD, 8'h21, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(in_ready[0]), 32'd0);
    rst = 1'b1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready[0]), 32'd1);
    chk("abort_out_valid", 32'(out_valid[0]), 32'd0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid[0]) n++;
    end
    chk("abort_no_result", 32'(n), 32'd0);
    send(0, 16'h00FF, 8'h10, 1'b1, 1'b0);
    wait_out(0, 16, 16'h000F, 8'h0F, 1'b0, "after_abort");

    // Randomized pairs with consumer stalls.
    rdy_mode[0] = 1;
    random_run(0, 2500);
    rdy_mode[1] = 1;
    random_run(1, 500);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
